// File: rtl/mult_div.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and signed divider (restoring on magnitudes).
// One operation at a time; results land in hi/lo on the edge that enters DONE.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] accHi_q, accHi_d;
  logic [31:0] accLo_q, accLo_d;
  logic [32:0] mcand_q, mcand_d;
  logic        bit_q, bit_d;
  logic        negQ_q, negQ_d;
  logic        negR_q, negR_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] mulSum;
  logic [32:0] remSh;
  logic [33:0] diff;
  logic [32:0] stepHi;
  logic [31:0] stepLo;
  logic        stepBit;
  logic [31:0] aAbs, bAbs;
  logic [31:0] quotOut, remOut;

  // One iteration of whichever algorithm is running. The 33-bit upper half keeps
  // Booth's add/subtract of 0x80000000 from overflowing before the arithmetic shift.
  always_comb begin
    mulSum = accHi_q;
    case ({accLo_q[0], bit_q})
      2'b01:   mulSum = accHi_q + mcand_q;
      2'b10:   mulSum = accHi_q - mcand_q;
      default: mulSum = accHi_q;
    endcase
    remSh = {accHi_q[31:0], accLo_q[31]};
    diff  = {1'b0, remSh} - {1'b0, mcand_q};
    if (state_q == MULT) begin
      stepHi  = {mulSum[32], mulSum[32:1]};
      stepLo  = {mulSum[0], accLo_q[31:1]};
      stepBit = accLo_q[0];
    end else begin
      stepBit = 1'b0;
      if (!diff[33]) begin
        stepHi = diff[32:0];
        stepLo = {accLo_q[30:0], 1'b1};
      end else begin
        stepHi = remSh;
        stepLo = {accLo_q[30:0], 1'b0};
      end
    end
    aAbs    = a[31] ? (32'd0 - a) : a;
    bAbs    = b[31] ? (32'd0 - b) : b;
    quotOut = negQ_q ? (32'd0 - stepLo) : stepLo;
    remOut  = negR_q ? (32'd0 - stepHi[31:0]) : stepHi[31:0];
  end

  // Next-state and register updates; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accHi_d = accHi_q;
    accLo_d = accLo_q;
    mcand_d = mcand_q;
    bit_d   = bit_q;
    negQ_d  = negQ_q;
    negR_d  = negR_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = 5'd0;
          accHi_d = 33'd0;
          bit_d   = 1'b0;
          dz_d    = 1'b0;
          if (!op) begin
            accLo_d = a;
            mcand_d = {b[31], b};
            state_d = MULT;
          end else if (b == 32'd0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            accLo_d = aAbs;
            mcand_d = {1'b0, bAbs};
            negQ_d  = a[31] ^ b[31];
            negR_d  = a[31];
            state_d = DIV;
          end
        end
      end
      MULT, DIV: begin
        accHi_d = stepHi;
        accLo_d = stepLo;
        bit_d   = stepBit;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          if (state_q == MULT) begin
            hi_d = stepHi[31:0];
            lo_d = stepLo;
          end else begin
            hi_d = remOut;
            lo_d = quotOut;
          end
        end
      end
      DONE: begin
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      accHi_q <= 33'd0;
      accLo_q <= 32'd0;
      mcand_q <= 33'd0;
      bit_q   <= 1'b0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      accHi_q <= accHi_d;
      accLo_q <= accLo_d;
      mcand_q <= mcand_d;
      bit_q   <= bit_d;
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = (state_q == DONE) && dz_q;

endmodule
